antares_cloz_gen: RTL and testbench
===================================

Name: antares_cloz_gen

Overview:
- Multi-cycle generator that is the inverse of the count-leading-ones/zeros function.
- Given a polarity, a count N (0..32) and a tail payload, it builds a 32-bit word with exactly N leading bits equal to the polarity. The next bit is the complement (when N<32), and the remaining low bits come from the tail.
- Sits beside the ALU/MDU in the Antares execute stage. It serves normalization and mask-building sequences, and acts as a self-check stimulus source for the CLO/CLZ path.

Parameters:
- STEP, 4, mask bits generated per RUN cycle. Legal values are 1, 2, 4, 8, 16 and 32; any other value is a synthesis error.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous active-high reset
- op_start  input  1  request; sampled only in IDLE
- op_flush  input  1  abort in-flight operation (pipeline flush/exception)
- op_polarity  input  1  0 = leading zeros, 1 = leading ones
- op_count  input  6  requested leading-bit count
- op_tail  input  32  payload for bits below the sentinel
- op_busy  output  1  high in RUN and DONE
- op_done  output  1  one-cycle pulse; op_result/op_error valid
- op_result  output  32  generated word; held until next op_done
- op_error  output  1  op_count>32 on the completed operation; held with op_result

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, op_busy=0, op_done=0, op_result=0, op_error=0, internal mask=0, remaining count=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - op_start=1 and op_flush=0: latch polarity, tail and count.
  - If count>32: remaining=32 and error flag=1; otherwise remaining=count and error flag=0.
  - mask=0, go to RUN.
  - op_start together with op_flush in IDLE: flush wins, request dropped.
- RUN, each cycle:
  - If remaining>=STEP: mask={STEP ones, mask[31:STEP]}, remaining-=STEP, stay in RUN.
  - Otherwise: shift in `remaining` ones (0 allowed), remaining=0, go to DONE.
  - Number of RUN cycles = floor(N/STEP)+1, where N is the effective count.
- DONE, one cycle:
  - Register the result. op_done=1 for exactly this cycle, then go to IDLE.
  - sentinel = ~mask & {1'b1, mask[31:1]}; it is one-hot, or zero when mask is all ones.
  - tailmask = ~(mask | sentinel).
  - polarity=1: op_result = mask | (op_tail & tailmask).
  - polarity=0: op_result = sentinel | (op_tail & tailmask).
- Error case: the count is saturated to 32, so the result is 32 copies of the polarity and op_error=1.
- Latency from op_start sampled high to op_done high = floor(N/STEP)+2 cycles.
  - STEP=4: N=0 gives 2 cycles, N=32 gives 10 cycles.
- op_start while busy is ignored; no queueing. A new start is accepted in the IDLE cycle that follows DONE.
- op_flush in RUN: go to IDLE next cycle. No op_done; op_result and op_error keep their previous values.
- op_flush in DONE: ignored, the completion stands.
- rst mid-operation: immediate return to reset values, no op_done.
- Invariant: for every non-error completion, a leading-zero/one count of op_result with the matching polarity equals op_count.
- Inputs other than op_start/op_flush are ignored outside the IDLE accept cycle.

Decomposition:
- Shared package antares_cloz_pkg:
  - state encoding constants CLOZ_IDLE, CLOZ_RUN, CLOZ_DONE
  - CLOZ_WIDTH=32, CLOZ_MAX_COUNT=6'd32
- Sub-module antares_cloz_assemble, purely combinational:
  - inputs: mask, polarity, tail
  - output: result
  - It is instantiated once and registered in DONE.
- The FSM, counter and mask shifter stay in antares_cloz_gen.

Test Plan:
- STEP=4, pol=0, count=0, tail=0x12345678 -> op_done 2 cycles after start, op_result=0x92345678 (bit31 sentinel=1), op_error=0.
- STEP=4, pol=1, count=5, tail=0xFFFFFFFF -> 3 cycles latency, op_result=0xFBFFFFFF, op_error=0.
- STEP=4, pol=0, count=32, tail=0xFFFFFFFF -> 10 cycles latency, op_result=0x00000000. Then pol=1, count=40 -> op_result=0xFFFFFFFF, op_error=1.
- STEP=4, pol=0, count=12: op_flush in 2nd RUN cycle -> no op_done, op_busy low next cycle, op_result unchanged. A restart with count=12, tail=0 gives 0x00080000.
- op_start pulsed every cycle while busy with count=3, then count=7 -> only the first is accepted. op_result=0x10000000 (pol=0, tail=0), one op_done pulse; op_start and op_flush together in IDLE -> no activity.
- Random sweep over all STEP values, counts 0..40, both polarities, random tails:
  - a CLO/CLZ model of op_result equals min(count,32).
  - op_error set iff count>32.
  - latency matches floor(N/STEP)+2.
  - rst asserted mid-RUN clears all outputs the next cycle.

Source files
------------

// File: rtl/antares_cloz_pkg.sv
// Shared types and constants for the inverse CLO/CLZ generator.
// The fill helper shifts ones in from the MSB side of a mask.
package antares_cloz_pkg;

  localparam int         CLOZ_WIDTH     = 32;
  localparam logic [5:0] CLOZ_MAX_COUNT = 6'd32;

  typedef enum logic [1:0] {
    CLOZ_IDLE = 2'd0,
    CLOZ_RUN  = 2'd1,
    CLOZ_DONE = 2'd2
  } cloz_state_e;

  // Complementing around the shift makes the vacated MSBs ones, so n=32 yields all ones.
  function automatic logic [CLOZ_WIDTH-1:0] cloz_fill_top(input logic [CLOZ_WIDTH-1:0] mask,
                                                          input logic [5:0]            n);
    return ~((~mask) >> n);
  endfunction

endpackage

// File: rtl/antares_cloz_assemble.sv
// Combinational result builder: leading-bit mask, sentinel just below it, tail underneath.
// No latency, no flow control.
module antares_cloz_assemble
  import antares_cloz_pkg::*;
(
  input  logic [CLOZ_WIDTH-1:0] mask_i,
  input  logic                  polarity_i,
  input  logic [CLOZ_WIDTH-1:0] tail_i,
  output logic [CLOZ_WIDTH-1:0] result_o
);

  logic [CLOZ_WIDTH-1:0] sentinel;
  logic [CLOZ_WIDTH-1:0] tailmask;

  // Sentinel is the first zero below the run of ones; zero when the mask is full.
  always_comb begin
    sentinel = ~mask_i & {1'b1, mask_i[CLOZ_WIDTH-1:1]};
    tailmask = ~(mask_i | sentinel);
    result_o = (polarity_i ? mask_i : sentinel) | (tail_i & tailmask);
  end

endmodule

// File: rtl/antares_cloz_gen.sv
// Inverse CLO/CLZ generator: builds a word with N leading polarity bits, a sentinel, then the tail.
// op_done floor(N/STEP)+2 cycles after an accepted start; starts while busy are dropped, flush aborts RUN.
module antares_cloz_gen
  import antares_cloz_pkg::*;
#(
  parameter int STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_start,
  input  logic        op_flush,
  input  logic        op_polarity,
  input  logic [5:0]  op_count,
  input  logic [31:0] op_tail,
  output logic        op_busy,
  output logic        op_done,
  output logic [31:0] op_result,
  output logic        op_error
);

  localparam logic [5:0] STEP_W = 6'(STEP);

  generate
    if (!(STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8 || STEP == 16 || STEP == 32)) begin : g_bad_step
      $error("antares_cloz_gen: STEP must be 1, 2, 4, 8, 16 or 32");
    end
  endgenerate

  cloz_state_e           state_q, state_d;
  logic [CLOZ_WIDTH-1:0] mask_q, mask_d;
  logic [CLOZ_WIDTH-1:0] tail_q, tail_d;
  logic [CLOZ_WIDTH-1:0] result_q, result_d;
  logic [CLOZ_WIDTH-1:0] assembled;
  logic [5:0]            rem_q, rem_d;
  logic                  pol_q, pol_d;
  logic                  pend_err_q, pend_err_d;
  logic                  error_q, error_d;
  logic                  done_q, done_d;
  logic                  accept, run_en, in_done;

  always_ff @(posedge clk) begin
    if (rst) state_q <= CLOZ_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CLOZ_IDLE: if (op_start && !op_flush) state_d = CLOZ_RUN;
      CLOZ_RUN: begin
        if (op_flush)              state_d = CLOZ_IDLE;
        else if (rem_q < STEP_W)   state_d = CLOZ_DONE;
      end
      CLOZ_DONE: state_d = CLOZ_IDLE;
      default:   state_d = CLOZ_IDLE;
    endcase
  end

  always_comb begin
    op_busy = (state_q == CLOZ_RUN) || (state_q == CLOZ_DONE);
    accept  = (state_q == CLOZ_IDLE) && op_start && !op_flush;
    run_en  = (state_q == CLOZ_RUN) && !op_flush;
    in_done = (state_q == CLOZ_DONE);
  end

  antares_cloz_assemble u_assemble (
    .mask_i     (mask_q),
    .polarity_i (pol_q),
    .tail_i     (tail_q),
    .result_o   (assembled)
  );

  always_comb begin
    mask_d     = mask_q;
    rem_d      = rem_q;
    pol_d      = pol_q;
    tail_d     = tail_q;
    pend_err_d = pend_err_q;
    if (accept) begin
      pol_d  = op_polarity;
      tail_d = op_tail;
      mask_d = '0;
      // Oversized counts saturate so the word becomes all polarity bits.
      if (op_count > CLOZ_MAX_COUNT) begin
        rem_d      = CLOZ_MAX_COUNT;
        pend_err_d = 1'b1;
      end else begin
        rem_d      = op_count;
        pend_err_d = 1'b0;
      end
    end else if (run_en) begin
      if (rem_q >= STEP_W) begin
        mask_d = cloz_fill_top(mask_q, STEP_W);
        rem_d  = rem_q - STEP_W;
      end else begin
        mask_d = cloz_fill_top(mask_q, rem_q);
        rem_d  = '0;
      end
    end
  end

  always_comb begin
    result_d = in_done ? assembled  : result_q;
    error_d  = in_done ? pend_err_q : error_q;
    done_d   = in_done;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q     <= '0;
      rem_q      <= '0;
      pol_q      <= 1'b0;
      tail_q     <= '0;
      pend_err_q <= 1'b0;
      result_q   <= '0;
      error_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      mask_q     <= mask_d;
      rem_q      <= rem_d;
      pol_q      <= pol_d;
      tail_q     <= tail_d;
      pend_err_q <= pend_err_d;
      result_q   <= result_d;
      error_q    <= error_d;
      done_q     <= done_d;
    end
  end

  assign op_done   = done_q;
  assign op_result = result_q;
  assign op_error  = error_q;

endmodule

// File: tb/tb_antares_cloz_gen.sv
// Bench for antares_cloz_gen: one instance per legal STEP sharing stimulus, with per-instance
// scoreboard queues checked whenever op_done fires.
module tb_antares_cloz_gen;

  localparam int NDUT = 6;

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          n_eff;
    logic        pol;
    int          lat;
    int          start_cyc;
  } exp_t;

  typedef struct {
    logic        pol;
    logic [5:0]  cnt;
    logic [31:0] tail;
    logic [31:0] exp_res;
    logic        exp_err;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            op_start = 1'b0;
  logic            op_flush = 1'b0;
  logic            op_polarity = 1'b0;
  logic [5:0]      op_count = '0;
  logic [31:0]     op_tail = '0;
  logic [NDUT-1:0] busy_w, done_w, err_w;
  logic [31:0]     res_w [NDUT];

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  exp_t        exp_q [NDUT][$];
  exp_t        mon_e;
  logic [31:0] last_res [NDUT];
  logic        last_err [NDUT];
  vec_t        vt [8];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    antares_cloz_gen #(.STEP(1 << g)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .op_start    (op_start),
      .op_flush    (op_flush),
      .op_polarity (op_polarity),
      .op_count    (op_count),
      .op_tail     (op_tail),
      .op_busy     (busy_w[g]),
      .op_done     (done_w[g]),
      .op_result   (res_w[g]),
      .op_error    (err_w[g])
    );
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL global_timeout actual=%0d cycles required=completion", cyc);
    $fatal(1, "bench timeout");
  end

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step=%0d actual=0x%08h required=0x%08h", name, 1 << idx, act, exp);
    end
  endtask

  function automatic logic [31:0] model_res(input logic pol, input logic [5:0] cnt, input logic [31:0] tail);
    logic [31:0] r;
    int ne;
    r  = tail;
    ne = (cnt > 6'd32) ? 32 : int'(cnt);
    for (int i = 0; i < 32; i++) begin
      if (i < ne)       r[31-i] = pol;
      else if (i == ne) r[31-i] = ~pol;
    end
    return r;
  endfunction

  function automatic int lead_cnt(input logic [31:0] v, input logic pol);
    int c;
    bit run;
    c   = 0;
    run = 1'b1;
    for (int i = 31; i >= 0; i--) begin
      if (run && v[i] == pol) c++;
      else run = 1'b0;
    end
    return c;
  endfunction

  function automatic int pending();
    int n;
    n = 0;
    for (int j = 0; j < NDUT; j++) n += exp_q[j].size();
    return n;
  endfunction

  task automatic push_exp(input logic pol, input logic [5:0] cnt, input logic [31:0] res,
                          input logic err, input logic [NDUT-1:0] who);
    exp_t e;
    e.n_eff     = (cnt > 6'd32) ? 32 : int'(cnt);
    e.res       = res;
    e.err       = err;
    e.pol       = pol;
    e.start_cyc = cyc + 1;
    for (int j = 0; j < NDUT; j++) begin
      if (who[j]) begin
        e.lat = e.n_eff / (1 << j) + 2;
        exp_q[j].push_back(e);
        last_res[j] = res;
        last_err[j] = err;
      end
    end
  endtask

  // Called #1 after a posedge; returns #1 after the accepting edge with junk on the data inputs.
  task automatic start_op(input logic pol, input logic [5:0] cnt, input logic [31:0] tail,
                          input logic [31:0] res, input logic err, input logic [NDUT-1:0] who);
    op_start    = 1'b1;
    op_polarity = pol;
    op_count    = cnt;
    op_tail     = tail;
    push_exp(pol, cnt, res, err, who);
    @(posedge clk); #1;
    op_start    = 1'b0;
    op_polarity = ~pol;
    op_count    = 6'($urandom);
    op_tail     = $urandom;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge clk); #1;
      ok = (pending() == 0);
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s_timeout actual=%0d pending required=0", name, pending());
      for (int j = 0; j < NDUT; j++) exp_q[j].delete();
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int j = 0; j < NDUT; j++) begin
        if (done_w[j]) begin
          if (exp_q[j].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done step=%0d actual=1 required=0", 1 << j);
          end else begin
            mon_e = exp_q[j].pop_front();
            check("result", j, res_w[j], mon_e.res);
            check("error", j, {31'b0, err_w[j]}, {31'b0, mon_e.err});
            check("latency", j, cyc - mon_e.start_cyc, mon_e.lat);
            check("lead_count", j, lead_cnt(res_w[j], mon_e.pol), mon_e.n_eff);
          end
        end
      end
    end
  end

  initial begin
    logic       p;
    logic [5:0] c;
    logic [31:0] t;

    vt[0] = '{1'b0, 6'd0,  32'h12345678, 32'h92345678, 1'b0};
    vt[1] = '{1'b1, 6'd5,  32'hFFFFFFFF, 32'hFBFFFFFF, 1'b0};
    vt[2] = '{1'b0, 6'd32, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vt[3] = '{1'b1, 6'd31, 32'h00000000, 32'hFFFFFFFE, 1'b0};
    vt[4] = '{1'b0, 6'd16, 32'hFFFFFFFF, 32'h0000FFFF, 1'b0};
    vt[5] = '{1'b1, 6'd1,  32'h00000000, 32'h80000000, 1'b0};
    vt[6] = '{1'b0, 6'd33, 32'hAAAAAAAA, 32'h00000000, 1'b1};
    vt[7] = '{1'b1, 6'd40, 32'h13579BDF, 32'hFFFFFFFF, 1'b1};
    for (int j = 0; j < NDUT; j++) begin
      last_res[j] = '0;
      last_err[j] = 1'b0;
    end

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int j = 0; j < NDUT; j++) begin
      check("reset_busy", j, busy_w[j], 0);
      check("reset_done", j, done_w[j], 0);
      check("reset_result", j, res_w[j], 0);
      check("reset_error", j, err_w[j], 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      start_op(vt[i].pol, vt[i].cnt, vt[i].tail, vt[i].exp_res, vt[i].exp_err, '1);
      wait_idle("table");
    end

    // Flush lands in the 2nd RUN cycle; STEP 16/32 are already in DONE and complete anyway.
    start_op(1'b0, 6'd12, 32'hDEADBEEF, model_res(1'b0, 6'd12, 32'hDEADBEEF), 1'b0, 6'b110000);
    @(posedge clk); #1;
    op_flush = 1'b1;
    @(posedge clk); #1;
    op_flush = 1'b0;
    for (int j = 0; j < 4; j++) begin
      check("flush_busy", j, busy_w[j], 0);
      check("flush_result_held", j, res_w[j], last_res[j]);
      check("flush_error_held", j, err_w[j], last_err[j]);
    end
    wait_idle("flush");
    repeat (10) @(posedge clk);
    #1;
    start_op(1'b0, 6'd12, 32'h0, 32'h00080000, 1'b0, '1);
    wait_idle("restart");

    // Start held high while busy: only the first request may be taken.
    op_start    = 1'b1;
    op_polarity = 1'b0;
    op_count    = 6'd3;
    op_tail     = 32'h0;
    push_exp(1'b0, 6'd3, 32'h10000000, 1'b0, '1);
    @(posedge clk); #1;
    op_polarity = 1'b1;
    op_count    = 6'd7;
    op_tail     = $urandom;
    repeat (2) @(posedge clk);
    #1;
    op_start = 1'b0;
    wait_idle("busy_start");
    repeat (15) @(posedge clk);
    #1;

    op_start = 1'b1;
    op_flush = 1'b1;
    op_count = 6'd5;
    @(posedge clk); #1;
    op_start = 1'b0;
    op_flush = 1'b0;
    for (int j = 0; j < NDUT; j++) check("start_flush_idle_busy", j, busy_w[j], 0);
    repeat (12) @(posedge clk);
    #1;

    for (int i = 0; i < 40; i++) begin
      p = 1'($urandom_range(0, 1));
      c = 6'($urandom_range(0, 40));
      t = $urandom;
      start_op(p, c, t, model_res(p, c, t), (c > 6'd32), '1);
      wait_idle("sweep");
    end

    // Leave nonzero outputs behind, then reset in the middle of RUN.
    start_op(1'b1, 6'd40, 32'h0, 32'hFFFFFFFF, 1'b1, '1);
    wait_idle("pre_reset");
    start_op(1'b1, 6'd32, 32'h0, 32'hFFFFFFFF, 1'b0, '0);
    rst = 1'b1;
    @(posedge clk); #1;
    for (int j = 0; j < NDUT; j++) begin
      check("midrun_rst_busy", j, busy_w[j], 0);
      check("midrun_rst_done", j, done_w[j], 0);
      check("midrun_rst_result", j, res_w[j], 0);
      check("midrun_rst_error", j, err_w[j], 0);
    end
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    start_op(1'b0, 6'd0, 32'h12345678, 32'h92345678, 1'b0, '1);
    wait_idle("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
